// File: rtl/seq_fixed_divider.sv
// -----------------------------------------------------------------------------
// seq_fixed_divider
//
// Sequential signed fixed-point divider: result = (a << FRAC) / b on
// two's-complement Q(IN_W-FRAC).FRAC operands. It uses restoring division,
// producing one quotient bit per clock (N = IN_W+FRAC steps). Both sides use
// valid/ready handshakes. The quotient saturates on overflow and on divide by
// zero.
//
// Parameters:
//   IN_W  operand/result width (signed)
//   FRAC  fractional bits shared by a, b and result
//
// Ports:
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   in_valid     operand pair valid
//   in_ready     divider idle and able to accept
//   a, b         dividend / divisor
//   out_valid    result and flags valid (held until out_ready)
//   out_ready    consumer accepts result
//   result       signed quotient
//   div_by_zero  b was zero, result saturated by sign of a
//   overflow     quotient out of range, result saturated
//
// Configuration macro:
//   SEQ_DIV_ROUND_EN  round half away from zero instead of truncating
// -----------------------------------------------------------------------------
module seq_fixed_divider #(
  parameter int IN_W = 32,
  parameter int FRAC = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] a,
  input  logic [IN_W-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IN_W-1:0] result,
  output logic            div_by_zero,
  output logic            overflow
);

  localparam int N     = IN_W + FRAC;
  localparam int CNT_W = $clog2(N + 1);

  localparam logic [IN_W-1:0] MAX_POS = {1'b0, {(IN_W-1){1'b1}}};
  localparam logic [IN_W-1:0] MIN_NEG = {1'b1, {(IN_W-1){1'b0}}};
  // Magnitude limits: negative results may reach 2^(IN_W-1), positive ones one less.
  localparam logic [N:0] LIM_POS = {{(N+2-IN_W){1'b0}}, {(IN_W-1){1'b1}}};
  localparam logic [N:0] LIM_NEG = {{(N+1-IN_W){1'b0}}, 1'b1, {(IN_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [N-1:0]     num_q, num_d;
  logic [IN_W:0]    rem_q, rem_d;
  logic [N-1:0]     q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic [IN_W-1:0]  b_abs_q, b_abs_d;
  logic [IN_W-1:0]  result_q, result_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  // ---------------------------------------------------------------------------
  // Operand conditioning. Magnitudes are unsigned IN_W bits so that the most
  // negative value maps to 2^(IN_W-1) without wrapping.
  // ---------------------------------------------------------------------------
  logic [IN_W-1:0] a_abs;
  logic [IN_W-1:0] b_abs;
  logic            b_is_zero;
  logic [IN_W-1:0] dbz_result;

  always_comb begin
    a_abs      = a[IN_W-1] ? (-a) : a;
    b_abs      = b[IN_W-1] ? (-b) : b;
    b_is_zero  = (b == '0);
    if (a == '0) begin
      dbz_result = '0;
    end else if (a[IN_W-1]) begin
      dbz_result = MIN_NEG;
    end else begin
      dbz_result = MAX_POS;
    end
  end

  // ---------------------------------------------------------------------------
  // One restoring-division step. The dividend is shifted out MSB first, which
  // is the same as indexing num[N-1-cnt] on an unshifted copy.
  // ---------------------------------------------------------------------------
  logic [IN_W:0] rem_shift;
  logic          rem_ge;
  logic [IN_W:0] rem_step;
  logic [N-1:0]  q_step;
  logic [N-1:0]  num_shift;
  logic          last_step;

  always_comb begin
    rem_shift = {rem_q[IN_W-1:0], num_q[N-1]};
    rem_ge    = (rem_shift >= {1'b0, b_abs_q});
    rem_step  = rem_ge ? (rem_shift - {1'b0, b_abs_q}) : rem_shift;
    q_step    = {q_q[N-2:0], rem_ge};
    num_shift = {num_q[N-2:0], 1'b0};
    last_step = (cnt_q == LAST_CNT);
  end

  // ---------------------------------------------------------------------------
  // Result formation from the final step's quotient and remainder. The extra
  // magnitude bit absorbs a rounding carry before the saturation check.
  // ---------------------------------------------------------------------------
  logic [N:0]      mag;
  logic [N:0]      mag_limit;
  logic            sat_ovf;
  logic [IN_W-1:0] sat_result;

  always_comb begin
    mag = {1'b0, q_step};
`ifdef SEQ_DIV_ROUND_EN
    // Half away from zero: remainder at least half the divisor bumps |q|.
    if ({rem_step, 1'b0} >= {2'b00, b_abs_q}) begin
      mag = mag + (N+1)'(1);
    end
`endif
    mag_limit = sign_q ? LIM_NEG : LIM_POS;
    sat_ovf   = (mag > mag_limit);
    if (sat_ovf) begin
      sat_result = sign_q ? MIN_NEG : MAX_POS;
    end else if (sign_q) begin
      sat_result = -mag[IN_W-1:0];
    end else begin
      sat_result = mag[IN_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = b_is_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready    = (state_q == IDLE);
    out_valid   = (state_q == DONE);
    result      = result_q;
    div_by_zero = dbz_q;
    overflow    = ovf_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    num_d    = num_q;
    rem_d    = rem_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    b_abs_d  = b_abs_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = a[IN_W-1] ^ b[IN_W-1];
          b_abs_d = b_abs;
          num_d   = {a_abs, {FRAC{1'b0}}};
          rem_d   = '0;
          q_d     = '0;
          cnt_d   = '0;
          if (b_is_zero) begin
            result_d = dbz_result;
            dbz_d    = 1'b1;
            ovf_d    = 1'b0;
          end
        end
      end
      CALC: begin
        num_d = num_shift;
        rem_d = rem_step;
        q_d   = q_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_step) begin
          result_d = sat_result;
          ovf_d    = sat_ovf;
          dbz_d    = 1'b0;
        end
      end
      DONE: begin
        // result intentionally keeps its value after the handoff.
        if (out_ready) begin
          dbz_d = 1'b0;
          ovf_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num_q    <= '0;
      rem_q    <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      b_abs_q  <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      num_q    <= num_d;
      rem_q    <= rem_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      b_abs_q  <= b_abs_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_seq_fixed_divider.sv
module tb_seq_fixed_divider;

  localparam int IN_W = 32;
  localparam int FRAC = 15;
  localparam int N    = IN_W + FRAC;

`ifdef SEQ_DIV_ROUND_EN
  localparam logic [31:0] EXP_THIRD_POS = 32'd10923;
  localparam logic [31:0] EXP_THIRD_NEG = 32'hFFFF_D555;  // -10923
`else
  localparam logic [31:0] EXP_THIRD_POS = 32'd10922;
  localparam logic [31:0] EXP_THIRD_NEG = 32'hFFFF_D556;  // -10922
`endif

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] a;
  logic [IN_W-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [IN_W-1:0] result;
  logic            div_by_zero;
  logic            overflow;

  int checks_cnt;
  int errors_cnt;

  seq_fixed_divider #(.IN_W(IN_W), .FRAC(FRAC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
    checks_cnt++;
    if (obs !== exp_val) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp_val);
    end
  endtask

  // One full transaction: accept, wait for result, optional backpressure,
  // optional in_valid noise while calculating, then hand the result off.
  task automatic run_div(input string name, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp_res, input logic exp_dbz, input logic exp_ovf,
                         input int exp_lat, input int hold, input bit noise);
    int lat;
    check_value({name, ":in_ready_before"}, {31'd0, in_ready}, 32'd1);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      if (noise) begin
        in_valid = 1'b1;
        a        = $urandom;
        b        = 32'd0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    check_value({name, ":latency"}, lat, exp_lat);
    check_value({name, ":out_valid"}, {31'd0, out_valid}, 32'd1);
    check_value({name, ":result"}, result, exp_res);
    check_value({name, ":div_by_zero"}, {31'd0, div_by_zero}, {31'd0, exp_dbz});
    check_value({name, ":overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
    check_value({name, ":in_ready_done"}, {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_value({name, ":hold_valid"}, {31'd0, out_valid}, 32'd1);
      check_value({name, ":hold_result"}, result, exp_res);
      check_value({name, ":hold_dbz"}, {31'd0, div_by_zero}, {31'd0, exp_dbz});
      check_value({name, ":hold_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
      check_value({name, ":hold_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_value({name, ":post_valid"}, {31'd0, out_valid}, 32'd0);
    check_value({name, ":post_in_ready"}, {31'd0, in_ready}, 32'd1);
    check_value({name, ":post_dbz"}, {31'd0, div_by_zero}, 32'd0);
    check_value({name, ":post_ovf"}, {31'd0, overflow}, 32'd0);
    check_value({name, ":post_result"}, result, exp_res);
    $display("txn %-12s a=0x%08h b=0x%08h -> result=0x%08h dbz=%0d ovf=%0d lat=%0d",
             name, av, bv, result, exp_dbz, exp_ovf, lat);
  endtask

  initial begin
    int cyc;
    checks_cnt = 0;
    errors_cnt = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    a          = '0;
    b          = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_value("rst:in_ready", {31'd0, in_ready}, 32'd1);
    check_value("rst:out_valid", {31'd0, out_valid}, 32'd0);
    check_value("rst:result", result, 32'd0);
    check_value("rst:dbz", {31'd0, div_by_zero}, 32'd0);
    check_value("rst:ovf", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Normal divisions
    run_div("basic",     32'd98304,      32'd65536,      32'd49152,      1'b0, 1'b0, N, 0, 1'b0);
    run_div("neg_a",     32'hFFFE_8000,  32'd65536,      32'hFFFF_4000,  1'b0, 1'b0, N, 0, 1'b0);
    run_div("neg_b",     32'd65536,      32'hFFFF_8000,  32'hFFFF_0000,  1'b0, 1'b0, N, 0, 1'b0);
    run_div("third",     32'd32768,      32'd98304,      EXP_THIRD_POS,  1'b0, 1'b0, N, 0, 1'b0);
    run_div("neg_third", 32'hFFFF_8000,  32'd98304,      EXP_THIRD_NEG,  1'b0, 1'b0, N, 0, 1'b0);
    // Range boundaries that just fit
    run_div("max_pos",   32'h7FFF_FFFF,  32'd32768,      32'h7FFF_FFFF,  1'b0, 1'b0, N, 0, 1'b0);
    run_div("min_neg",   32'h8000_0000,  32'd32768,      32'h8000_0000,  1'b0, 1'b0, N, 0, 1'b0);
    // Overflow
    run_div("ovf_pos",   32'h7FFF_FFFF,  32'd1,          32'h7FFF_FFFF,  1'b0, 1'b1, N, 0, 1'b0);
    run_div("ovf_neg",   32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0, 1'b1, N, 0, 1'b0);
    // Divide by zero: result visible in the cycle right after the accept
    run_div("dbz_pos",   32'd5,          32'd0,          32'h7FFF_FFFF,  1'b1, 1'b0, 0, 0, 1'b0);
    run_div("dbz_neg",   32'hFFFF_FFFB,  32'd0,          32'h8000_0000,  1'b1, 1'b0, 0, 0, 1'b0);
    run_div("dbz_zero",  32'd0,          32'd0,          32'd0,          1'b1, 1'b0, 0, 0, 1'b0);
    // Backpressure and in_valid noise during CALC
    run_div("hold5",     32'd98304,      32'd65536,      32'd49152,      1'b0, 1'b0, N, 5, 1'b0);
    run_div("noise",     32'hFFFE_8000,  32'd65536,      32'hFFFF_4000,  1'b0, 1'b0, N, 0, 1'b1);

    // Back-to-back with out_ready held high and in_valid held high
    out_ready = 1'b1;
    a         = 32'd98304;
    b         = 32'd65536;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    while (!in_ready && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_value("b2b:ready_gap", cyc, N + 1);
    a = 32'hFFFE_8000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_value("b2b:latency", cyc, N);
    check_value("b2b:result", result, 32'hFFFF_4000);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_value("b2b:idle", {31'd0, in_ready}, 32'd1);
    $display("txn %-12s two accepts, ready gap checked, result=0x%08h", "b2b", result);

    // Reset mid-CALC
    a        = 32'd98304;
    b        = 32'd65536;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_value("midrst:in_ready", {31'd0, in_ready}, 32'd1);
    check_value("midrst:out_valid", {31'd0, out_valid}, 32'd0);
    check_value("midrst:result", result, 32'd0);
    $display("txn %-12s reset at CALC step 20", "midrst");
    run_div("after_rst", 32'd32768,      32'd98304,      EXP_THIRD_POS,  1'b0, 1'b0, N, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
